// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// The decoder's native output is active-low (common-anode board).
package seg7_pkg;

   localparam logic [6:0] SEG_OFF_LOW  = 7'h7F;
   localparam logic [6:0] SEG_OFF_HIGH = 7'h00;

   typedef enum logic {
      BLANK = 1'b0,
      ON    = 1'b1
   } scan_state_e;

   // Ceiling log2 with a floor of one bit so single-value ranges still get a register.
   function automatic int clog2(input int n);
      int w;
      int v;
      w = 0;
      v = n - 1;
      while (v > 0) begin
         w = w + 1;
         v = v >> 1;
      end
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/Seg7decode.sv
// Hex nibble to seven-segment pattern {g,f,e,d,c,b,a}, active-low (0 = segment lit).
module Seg7decode (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h7F;
      case (nibble)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS common-anode digits through one shared decoder,
// with per-frame input snapshot, dead-time blanking, digit masking and leading-zero blanking.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int TICK_DIV       = 50000,
   parameter int BLANK_CYCLES   = 500,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   digit_mask,
   input  logic                    lz_suppress,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg7,
   output logic                    frame_done
);

   localparam int CNT_W = clog2(TICK_DIV);
   localparam int IDX_W = clog2(NUM_DIGITS);
   localparam logic [6:0]       SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? SEG_OFF_LOW : SEG_OFF_HIGH;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   scan_state_e             state;
   logic [IDX_W-1:0]        idx;
   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        cnt_next;
   logic                    slot_end;
   logic [4*NUM_DIGITS-1:0] shadow_value;
   logic [NUM_DIGITS-1:0]   shadow_mask;
   logic                    shadow_lz;
   logic [3:0]              nibbles [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   lz_blank;
   logic [NUM_DIGITS-1:0]   visible;
   logic                    zero_above;
   logic [6:0]              dec_seg;
   logic [6:0]              pol_seg;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nibble
      assign nibbles[g] = shadow_value[4*g +: 4];
   end

   // A digit is lz-blanked when it and every more significant digit are zero; digit 0 always shows.
   always_comb begin
      zero_above = 1'b1;
      lz_blank   = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_above  = zero_above & (nibbles[i] == 4'h0);
         lz_blank[i] = shadow_lz & zero_above & (i != 0);
      end
   end

   assign visible  = shadow_mask & ~lz_blank;
   assign slot_end = (cnt == CNT_LAST);
   assign cnt_next = slot_end ? '0 : cnt + 1'b1;

   Seg7decode u_decode (
      .nibble (nibbles[idx]),
      .seg    (dec_seg)
   );

   assign pol_seg = (SEG_ACTIVE_LOW != 0) ? dec_seg : ~dec_seg;

   // Scan FSM; pins are driven from the pre-edge state so they lag the counter by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= BLANK;
         idx          <= '0;
         cnt          <= '0;
         shadow_value <= '0;
         shadow_mask  <= '0;
         shadow_lz    <= 1'b0;
         an           <= '1;
         seg7         <= SEG_OFF;
         frame_done   <= 1'b0;
      end else begin
         cnt   <= cnt_next;
         state <= (cnt_next < CNT_BLANK) ? BLANK : ON;
         if (slot_end) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end
         if (state == BLANK && idx == '0 && cnt == '0) begin
            shadow_value <= value;
            shadow_mask  <= digit_mask;
            shadow_lz    <= lz_suppress;
         end
         frame_done <= slot_end && (idx == IDX_LAST);
         if (state == ON && visible[idx]) begin
            an   <= ~(NUM_DIGITS'(1) << idx);
            seg7 <= pol_seg;
         end else begin
            an   <= '1;
            seg7 <= SEG_OFF;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: each scenario task compares the pins every cycle
// against a frame-level model built from slot arithmetic and a per-frame input snapshot.
module tb_seg7_scan_ctrl;

   localparam int N     = 4;
   localparam int T     = 8;
   localparam int B     = 2;
   localparam int FRAME = N * T;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] value = 16'h0000;
   logic [3:0]  digit_mask = 4'h0;
   logic        lz_suppress = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg7;
   logic        frame_done;

   int checks = 0;
   int errors = 0;
   int m = -1;
   bit in_reset = 1'b1;
   logic [15:0] snap_value = 16'h0000;
   logic [3:0]  snap_mask = 4'h0;
   logic        snap_lz = 1'b0;

   logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   seg7_scan_ctrl #(
      .NUM_DIGITS     (N),
      .TICK_DIV       (T),
      .BLANK_CYCLES   (B),
      .SEG_ACTIVE_LOW (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .value       (value),
      .digit_mask  (digit_mask),
      .lz_suppress (lz_suppress),
      .an          (an),
      .seg7        (seg7),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   // m counts edges since reset release; inputs are captured at every frame-start edge.
   task automatic step();
      @(posedge clk);
      if (rst) begin
         in_reset = 1'b1;
         m = -1;
      end else begin
         in_reset = 1'b0;
         m = m + 1;
         if (m % FRAME == 0) begin
            snap_value = value;
            snap_mask  = digit_mask;
            snap_lz    = lz_suppress;
         end
      end
      #1;
   endtask

   function automatic void model(output logic [3:0] ea, output logic [6:0] es, output logic ef);
      int slot;
      int pos;
      logic [3:0] nib;
      bit vis;
      ea = 4'hF;
      es = 7'h7F;
      ef = 1'b0;
      if (!in_reset && m >= 0) begin
         ef   = ((m % FRAME) == FRAME - 1);
         slot = (m / T) % N;
         pos  = m % T;
         nib  = 4'((snap_value >> (4 * slot)) & 16'h000F);
         vis  = snap_mask[slot] && !(snap_lz && slot != 0 && (snap_value >> (4 * slot)) == 16'h0000);
         if (pos >= B && vis) begin
            ea = ~(4'b0001 << slot);
            es = font[nib];
         end
      end
   endfunction

   task automatic randomize_inputs();
      int keep;
      value = 16'($urandom);
      keep  = $urandom_range(0, 4);
      if (keep < 4) value = value & 16'((1 << (4 * keep)) - 1);
      digit_mask  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      lz_suppress = 1'($urandom_range(0, 1));
   endtask

   task automatic test_reset();
      logic [3:0] ea;
      logic [6:0] es;
      logic ef;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         model(ea, es, ef);
         checks++;
         if (an !== 4'hF || seg7 !== 7'h7F || frame_done !== 1'b0 || an !== ea) begin
            errors++;
            $display("[TB] FAIL reset k=%0d an=%b seg7=%h frame_done=%b (need F/7F/0)", k, an, seg7, frame_done);
         end
      end
   endtask

   task automatic test_basic();
      logic [3:0] ea;
      logic [6:0] es;
      logic ef;
      value = 16'h1234;
      digit_mask = 4'hF;
      lz_suppress = 1'b0;
      rst = 1'b0;
      for (int k = 0; k < 2 * FRAME; k++) begin
         step();
         model(ea, es, ef);
         checks++;
         if (an !== ea || seg7 !== es || frame_done !== ef) begin
            errors++;
            $display("[TB] FAIL basic m=%0d an=%b/%b seg7=%h/%h frame_done=%b/%b (got/exp)", m, an, ea, seg7, es, frame_done, ef);
         end
         if (m == 2) begin
            checks++;
            if (an !== 4'b1110 || seg7 !== 7'h19) begin
               errors++;
               $display("[TB] FAIL basic_digit0 an=%b seg7=%h (need 1110/19)", an, seg7);
            end
         end
         if (m == FRAME - 1) begin
            checks++;
            if (frame_done !== 1'b1) begin
               errors++;
               $display("[TB] FAIL basic_frame_done got %b need 1", frame_done);
            end
         end
      end
   endtask

   task automatic test_snapshot();
      logic [3:0] ea;
      logic [6:0] es;
      logic ef;
      for (int k = 0; k < 2 * FRAME; k++) begin
         step();
         if (m % FRAME == 12 && k < FRAME) value = 16'h5678;
         model(ea, es, ef);
         checks++;
         if (an !== ea || seg7 !== es || frame_done !== ef) begin
            errors++;
            $display("[TB] FAIL snapshot m=%0d an=%b/%b seg7=%h/%h frame_done=%b/%b (got/exp)", m, an, ea, seg7, es, frame_done, ef);
         end
      end
   endtask

   task automatic test_lz();
      logic [3:0] ea;
      logic [6:0] es;
      logic ef;
      value = 16'h0070;
      lz_suppress = 1'b1;
      digit_mask = 4'hF;
      for (int k = 0; k < 4 * FRAME; k++) begin
         step();
         if (k == 2 * FRAME) value = 16'h0000;
         model(ea, es, ef);
         checks++;
         if (an !== ea || seg7 !== es || frame_done !== ef) begin
            errors++;
            $display("[TB] FAIL lz m=%0d an=%b/%b seg7=%h/%h frame_done=%b/%b (got/exp)", m, an, ea, seg7, es, frame_done, ef);
         end
      end
   endtask

   task automatic test_mask();
      logic [3:0] ea;
      logic [6:0] es;
      logic ef;
      value = 16'h9A0C;
      lz_suppress = 1'b0;
      digit_mask = 4'b0101;
      for (int k = 0; k < 3 * FRAME; k++) begin
         step();
         model(ea, es, ef);
         checks++;
         if (an !== ea || seg7 !== es || frame_done !== ef) begin
            errors++;
            $display("[TB] FAIL mask m=%0d an=%b/%b seg7=%h/%h frame_done=%b/%b (got/exp)", m, an, ea, seg7, es, frame_done, ef);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] ea;
      logic [6:0] es;
      logic ef;
      for (int k = 0; k < 10 * FRAME; k++) begin
         step();
         if ($urandom_range(0, 7) == 0) randomize_inputs();
         model(ea, es, ef);
         checks++;
         if (an !== ea || seg7 !== es || frame_done !== ef) begin
            errors++;
            $display("[TB] FAIL random m=%0d an=%b/%b seg7=%h/%h frame_done=%b/%b (got/exp)", m, an, ea, seg7, es, frame_done, ef);
         end
      end
   endtask

   task automatic test_reset_midscan();
      logic [3:0] ea;
      logic [6:0] es;
      logic ef;
      bit found;
      found = 1'b0;
      value = 16'h4321;
      digit_mask = 4'hF;
      lz_suppress = 1'b0;
      for (int k = 0; k < 2 * FRAME && !found; k++) begin
         step();
         model(ea, es, ef);
         checks++;
         if (an !== ea || seg7 !== es || frame_done !== ef) begin
            errors++;
            $display("[TB] FAIL midscan_wait m=%0d an=%b/%b seg7=%h/%h (got/exp)", m, an, ea, seg7, es);
         end
         if (m % FRAME == 20) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("[TB] FAIL midscan_timeout m=%0d never reached slot 2", m);
      end
      rst = 1'b1;
      step();
      checks++;
      if (an !== 4'hF || seg7 !== 7'h7F || frame_done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midscan_reset an=%b seg7=%h frame_done=%b (need F/7F/0)", an, seg7, frame_done);
      end
      rst = 1'b0;
      randomize_inputs();
      digit_mask[0] = 1'b1;
      for (int k = 0; k < 2 * FRAME; k++) begin
         step();
         model(ea, es, ef);
         checks++;
         if (an !== ea || seg7 !== es || frame_done !== ef) begin
            errors++;
            $display("[TB] FAIL midscan_restart m=%0d an=%b/%b seg7=%h/%h frame_done=%b/%b (got/exp)", m, an, ea, seg7, es, frame_done, ef);
         end
         if (m == 2) begin
            checks++;
            if (an !== 4'b1110) begin
               errors++;
               $display("[TB] FAIL midscan_digit0 an=%b need 1110", an);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_snapshot();
      test_lz();
      test_mask();
      test_random();
      test_reset_midscan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
